// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants for the VGA timing generator: counter width, the
// 640x480@60 default timing and the derived line/frame totals.
// No ports (package).
package vga_timing_pkg;

    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1024;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Length of one axis period (line or frame) from its four segments.
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_axis.sv
// timing_axis
// One timing axis (horizontal or vertical): a wrapping counter plus the
// registered active/sync decode of the value being loaded.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en       : update the registers this clk
//   zero     : when updating, load count 0 instead of advancing
//   inc      : when updating (and not zero), advance by one; else hold
//   count    : current counter value (registered)
//   active   : count < ACTIVE (registered, 0 in reset)
//   sync     : POL inside the sync window, ~POL elsewhere (registered)
//   wrap     : count is at the last position of the period
module timing_axis
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             zero,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             active,
    output logic             sync,
    output logic             wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] next_s;

    assign wrap = (count == LAST);

    // Next counter value: forced zero, advance with wrap, or hold.
    always_comb begin
        next_s = count;
        if (zero) begin
            next_s = {CNT_W{1'b0}};
        end else if (inc) begin
            if (wrap) begin
                next_s = {CNT_W{1'b0}};
            end else begin
                next_s = count + CNT_W'(1);
            end
        end else begin
            next_s = count;
        end
    end

    // Counter and decodes are registered together from next_s so they
    // always describe the same position.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= {CNT_W{1'b0}};
            active <= 1'b0;
            sync   <= ~POL;
        end else if (en) begin
            count  <= next_s;
            active <= (next_s < ACT_END);
            sync   <= ((next_s >= SYNC_LO) && (next_s < SYNC_HI)) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// vga_timing
// VGA raster timing generator advancing one pixel per clk with pix_ce=1.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   pix_ce       : pixel clock enable
//   px, py       : current horizontal / vertical position (incl. blanking)
//   video_active : position is inside the visible area
//   hsync, vsync : sync outputs, asserted level set by *_POL
//   line_start   : one-clk pulse after the update that loads px=0
//   frame_start  : one-clk pulse after the update that loads (0,0)
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] px,
    output logic [CNT_W-1:0] py,
    output logic             video_active,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOT > MAX_TOTAL) begin : g_h_total_too_large
        $error("vga_timing: horizontal total exceeds counter range");
    end
    if (V_TOT > MAX_TOTAL) begin : g_v_total_too_large
        $error("vga_timing: vertical total exceeds counter range");
    end

    // Low until the first pixel after reset; that pixel loads (0,0)
    // rather than advancing from the reset count.
    logic primed_r;
    logic h_wrap_s;
    logic v_wrap_s;
    logic h_active_s;
    logic v_active_s;

    timing_axis #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HSYNC_POL)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .en     (pix_ce),
        .zero   (~primed_r),
        .inc    (1'b1),
        .count  (px),
        .active (h_active_s),
        .sync   (hsync),
        .wrap   (h_wrap_s)
    );

    timing_axis #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VSYNC_POL)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .en     (pix_ce),
        .zero   (~primed_r),
        .inc    (h_wrap_s),
        .count  (py),
        .active (v_active_s),
        .sync   (vsync),
        .wrap   (v_wrap_s)
    );

    // Both terms are flops updated on the same pixel, so this stays aligned
    // and has no path from pix_ce.
    assign video_active = h_active_s & v_active_s;

    // Start pulses: set by the update that loads px=0 / (0,0) and cleared on
    // the very next clk whether or not pix_ce is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            primed_r    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pix_ce & (~primed_r | h_wrap_s);
            frame_start <= pix_ce & (~primed_r | (h_wrap_s & v_wrap_s));
            if (pix_ce) begin
                primed_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing
// Self-checking bench: a default 640x480 instance and a small-raster
// instance share clk/rst/pix_ce; a position-index model predicts every
// output of both on every clk.
module tb_vga_timing;

    logic       clk;
    logic       rst;
    logic       pix_ce;

    logic [9:0] px_d, py_d, px_s, py_s;
    logic       va_d, hs_d, vs_d, ls_d, fs_d;
    logic       va_s, hs_s, vs_s, ls_s, fs_s;

    int n_checks = 0;
    int n_err    = 0;

    // Model configuration: index 0 = default raster, 1 = small raster.
    int ha [2] = '{640, 8};
    int hf [2] = '{16, 2};
    int hs [2] = '{96, 3};
    int hb [2] = '{48, 2};
    int va [2] = '{480, 4};
    int vf [2] = '{10, 1};
    int vs [2] = '{2, 2};
    int vb [2] = '{33, 1};
    bit hp [2] = '{1'b0, 1'b1};
    bit vp [2] = '{1'b0, 1'b0};

    // Model state: pixels shown since the frame began, plus pulse flags.
    bit started [2];
    int pos     [2];
    bit m_ls    [2];
    bit m_fs    [2];

    vga_timing u_def (
        .clk          (clk),
        .rst          (rst),
        .pix_ce       (pix_ce),
        .px           (px_d),
        .py           (py_d),
        .video_active (va_d),
        .hsync        (hs_d),
        .vsync        (vs_d),
        .line_start   (ls_d),
        .frame_start  (fs_d)
    );

    vga_timing #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b0)
    ) u_small (
        .clk          (clk),
        .rst          (rst),
        .pix_ce       (pix_ce),
        .px           (px_s),
        .py           (py_s),
        .video_active (va_s),
        .hsync        (hs_s),
        .vsync        (vs_s),
        .line_start   (ls_s),
        .frame_start  (fs_s)
    );

    logic [24:0] obs_def, obs_small;
    assign obs_def   = {px_d, py_d, va_d, hs_d, vs_d, ls_d, fs_d};
    assign obs_small = {px_s, py_s, va_s, hs_s, vs_s, ls_s, fs_s};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int htot(input int i);
        return ha[i] + hf[i] + hs[i] + hb[i];
    endfunction

    function automatic int vtot(input int i);
        return va[i] + vf[i] + vs[i] + vb[i];
    endfunction

    // Expected output vector {px,py,video_active,hsync,vsync,ls,fs}.
    function automatic logic [24:0] exp_vec(input int i);
        int  x, y;
        bit  e_va, e_hs, e_vs;
        if (!started[i]) begin
            return {10'd0, 10'd0, 1'b0, ~hp[i], ~vp[i], 1'b0, 1'b0};
        end
        x    = pos[i] % htot(i);
        y    = pos[i] / htot(i);
        e_va = (x < ha[i]) && (y < va[i]);
        e_hs = (x >= ha[i] + hf[i] && x < ha[i] + hf[i] + hs[i]) ? hp[i] : ~hp[i];
        e_vs = (y >= va[i] + vf[i] && y < va[i] + vf[i] + vs[i]) ? vp[i] : ~vp[i];
        return {10'(x), 10'(y), e_va, e_hs, e_vs, m_ls[i], m_fs[i]};
    endfunction

    // Drive one clk of stimulus, advance the model, return at the negedge.
    task automatic step(input logic r, input logic ce);
        rst    = r;
        pix_ce = ce;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                started[i] = 1'b0;
                pos[i]     = 0;
                m_ls[i]    = 1'b0;
                m_fs[i]    = 1'b0;
            end else if (ce) begin
                pos[i]     = started[i] ? (pos[i] + 1) % (htot(i) * vtot(i)) : 0;
                started[i] = 1'b1;
                m_ls[i]    = (pos[i] % htot(i)) == 0;
                m_fs[i]    = (pos[i] == 0);
            end else begin
                m_ls[i] = 1'b0;
                m_fs[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
        n_checks++;
        if (obs_def !== exp_vec(0)) begin
            n_err++;
            $display("FAIL reset_def obs=%h exp=%h", obs_def, exp_vec(0));
        end
        n_checks++;
        if (obs_small !== exp_vec(1)) begin
            n_err++;
            $display("FAIL reset_small obs=%h exp=%h", obs_small, exp_vec(1));
        end
        step(1'b0, 1'b1);
        n_checks++;
        if ({px_d, py_d, va_d, ls_d, fs_d} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL first_pixel obs=%h exp=%h", {px_d, py_d, va_d, ls_d, fs_d},
                     {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
        end
        step(1'b0, 1'b1);
        n_checks++;
        if (fs_d !== 1'b0) begin
            n_err++;
            $display("FAIL frame_start_width obs=%b exp=0", fs_d);
        end
    endtask

    task automatic test_line;
        int hs_low = 0, ls_cnt = 0, ls_first = -1, ls_gap = 0;
        logic [9:0] prev_px = 10'd0;
        step(1'b1, 1'b0);
        for (int k = 0; k < 1600; k++) begin
            prev_px = px_d;
            step(1'b0, 1'b1);
            n_checks++;
            if (obs_def !== exp_vec(0)) begin
                n_err++;
                $display("FAIL line_def k=%0d obs=%h exp=%h", k, obs_def, exp_vec(0));
            end
            if (hs_d === 1'b0) hs_low++;
            if (ls_d === 1'b1) begin
                if (ls_first < 0) ls_first = k; else ls_gap = k - ls_first;
                ls_cnt++;
            end
            if (px_d == 10'd639) begin
                n_checks++;
                if (va_d !== 1'b1) begin
                    n_err++;
                    $display("FAIL active_px639 obs=%b exp=1", va_d);
                end
            end
            if (px_d == 10'd640) begin
                n_checks++;
                if (va_d !== 1'b0) begin
                    n_err++;
                    $display("FAIL active_px640 obs=%b exp=0", va_d);
                end
            end
            if (k > 0 && prev_px == 10'd799) begin
                n_checks++;
                if (px_d !== 10'd0) begin
                    n_err++;
                    $display("FAIL px_wrap obs=%0d exp=0", px_d);
                end
            end
        end
        n_checks++;
        if (hs_low != 192) begin
            n_err++;
            $display("FAIL hsync_low_count obs=%0d exp=192", hs_low);
        end
        n_checks++;
        if (ls_cnt != 2 || ls_gap != 800) begin
            n_err++;
            $display("FAIL line_start_period obs=%0d/%0d exp=2/800", ls_cnt, ls_gap);
        end
    endtask

    task automatic test_frame;
        int fs_cnt = 0, vs_low = 0;
        logic [9:0] prev_py = 10'd0;
        step(1'b1, 1'b0);
        for (int k = 0; k < 360; k++) begin
            prev_py = py_s;
            step(1'b0, 1'b1);
            n_checks++;
            if (obs_small !== exp_vec(1)) begin
                n_err++;
                $display("FAIL frame_small k=%0d obs=%h exp=%h", k, obs_small, exp_vec(1));
            end
            if (fs_s === 1'b1) fs_cnt++;
            if (vs_s === 1'b0) vs_low++;
            if (k > 0 && prev_py == 10'd7 && py_s != 10'd7) begin
                n_checks++;
                if (py_s !== 10'd0) begin
                    n_err++;
                    $display("FAIL py_wrap obs=%0d exp=0", py_s);
                end
            end
        end
        n_checks++;
        if (fs_cnt != 3) begin
            n_err++;
            $display("FAIL frame_start_count obs=%0d exp=3", fs_cnt);
        end
        n_checks++;
        if (vs_low != 90) begin
            n_err++;
            $display("FAIL vsync_low_count obs=%0d exp=90", vs_low);
        end
    endtask

    task automatic test_duty;
        int   fs_cnt = 0;
        logic prev_fs = 1'b0;
        step(1'b1, 1'b0);
        for (int k = 0; k < 4000; k++) begin
            prev_fs = fs_s;
            step(1'b0, (k % 4) == 0);
            n_checks++;
            if (obs_def !== exp_vec(0)) begin
                n_err++;
                $display("FAIL duty_def k=%0d obs=%h exp=%h", k, obs_def, exp_vec(0));
            end
            n_checks++;
            if (obs_small !== exp_vec(1)) begin
                n_err++;
                $display("FAIL duty_small k=%0d obs=%h exp=%h", k, obs_small, exp_vec(1));
            end
            if (fs_s === 1'b1) begin
                fs_cnt++;
                n_checks++;
                if (prev_fs !== 1'b0) begin
                    n_err++;
                    $display("FAIL duty_fs_width obs=%b exp=0 before pulse", prev_fs);
                end
            end
        end
        n_checks++;
        if (fs_cnt != (1000 + 119) / 120) begin
            n_err++;
            $display("FAIL duty_fs_count obs=%0d exp=%0d", fs_cnt, (1000 + 119) / 120);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0);
            n_checks++;
            if (obs_def !== exp_vec(0)) begin
                n_err++;
                $display("FAIL rand_def k=%0d obs=%h exp=%h", k, obs_def, exp_vec(0));
            end
            n_checks++;
            if (obs_small !== exp_vec(1)) begin
                n_err++;
                $display("FAIL rand_small k=%0d obs=%h exp=%h", k, obs_small, exp_vec(1));
            end
        end
    endtask

    task automatic test_midframe_reset;
        int guard = 0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        while (!(px_d == 10'd320 && py_d == 10'd1) && guard < 3000) begin
            step(1'b0, 1'b1);
            guard++;
        end
        n_checks++;
        if (guard >= 3000) begin
            n_err++;
            $display("FAIL midframe_reach obs=%0d,%0d exp=320,1", px_d, py_d);
        end
        step(1'b1, 1'b1);
        n_checks++;
        if (obs_def !== exp_vec(0)) begin
            n_err++;
            $display("FAIL midrst_def obs=%h exp=%h", obs_def, exp_vec(0));
        end
        n_checks++;
        if (obs_small !== exp_vec(1)) begin
            n_err++;
            $display("FAIL midrst_small obs=%h exp=%h", obs_small, exp_vec(1));
        end
        step(1'b0, 1'b1);
        n_checks++;
        if ({px_d, py_d, fs_d, ls_d} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL midrst_restart obs=%h exp=%h", {px_d, py_d, fs_d, ls_d},
                     {10'd0, 10'd0, 1'b1, 1'b1});
        end
        n_checks++;
        if (obs_small !== exp_vec(1)) begin
            n_err++;
            $display("FAIL midrst_restart_small obs=%h exp=%h", obs_small, exp_vec(1));
        end
    endtask

    initial begin
        rst    = 1'b1;
        pix_ce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            started[i] = 1'b0;
            pos[i]     = 0;
            m_ls[i]    = 1'b0;
            m_fs[i]    = 1'b0;
        end
        test_reset();
        test_line();
        test_frame();
        test_duty();
        test_random();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
